// File: rtl/seq_divider_if.sv
// rtl/seq_divider_if.sv - start/busy/done handshake and operand/result bundle for seq_divider
`timescale 1ns/1ps
interface seq_divider_if #(
   parameter int DW = 8,
   parameter int VW = 4
);
   logic          start;
   logic [DW-1:0] dividend;
   logic [VW-1:0] divisor;
   logic          busy;
   logic          done;
   logic [DW-1:0] quotient;
   logic [VW-1:0] remainder;
   logic          div_by_zero;

   modport master (
      output start, dividend, divisor,
      input  busy, done, quotient, remainder, div_by_zero
   );

   modport slave (
      input  start, dividend, divisor,
      output busy, done, quotient, remainder, div_by_zero
   );
endinterface

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - multi-cycle restoring divider, one quotient bit per clock
`timescale 1ns/1ps
module seq_divider #(
   parameter int DW = 8,
   parameter int VW = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   seq_divider_if.slave bus
);
   localparam int CW = (DW > 1) ? $clog2(DW) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_CALC,
      S_DONE
   } state_t;

   state_t         r_state;
   state_t         w_state_next;
   logic [CW-1:0]  r_count;
   logic [DW-1:0]  r_dvd;
   logic [VW-1:0]  r_dvs;
   logic [VW-1:0]  r_prem;
   logic [DW-1:0]  r_quo_w;
   logic [DW-1:0]  r_quotient;
   logic [VW-1:0]  r_remainder;
   logic           r_dbz;

   logic           w_accept;
   logic           w_zero;
   logic           w_last;
   logic [VW:0]    w_shift;
   logic           w_ge;
   logic [VW-1:0]  w_sub;
   logic [VW-1:0]  w_prem_next;
   logic [DW-1:0]  w_quo_next;

   assign w_accept = bus.start && (r_state != S_CALC);
   assign w_zero   = (bus.divisor == '0);
   assign w_last   = (r_count == '0);

   // The restored partial remainder is always below the divisor, so only the
   // shifted value needs the extra bit; the subtraction result fits in VW bits.
   assign w_shift     = {r_prem, r_dvd[DW-1]};
   assign w_ge        = (w_shift >= {1'b0, r_dvs});
   assign w_sub       = w_shift[VW-1:0] - r_dvs;
   assign w_prem_next = w_ge ? w_sub : w_shift[VW-1:0];
   assign w_quo_next  = {r_quo_w[DW-2:0], w_ge};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE, S_DONE: begin
            if (w_accept) begin
               w_state_next = w_zero ? S_DONE : S_CALC;
            end else begin
               w_state_next = S_IDLE;
            end
         end
         S_CALC: begin
            if (w_last) begin
               w_state_next = S_DONE;
            end
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count     <= '0;
         r_dvd       <= '0;
         r_dvs       <= '0;
         r_prem      <= '0;
         r_quo_w     <= '0;
         r_quotient  <= '0;
         r_remainder <= '0;
         r_dbz       <= 1'b0;
      end else begin
         if (r_state == S_CALC) begin
            r_prem  <= w_prem_next;
            r_dvd   <= {r_dvd[DW-2:0], 1'b0};
            r_quo_w <= w_quo_next;
            r_count <= r_count - CW'(1);
            if (w_last) begin
               r_quotient  <= w_quo_next;
               r_remainder <= w_prem_next;
               r_dbz       <= 1'b0;
            end
         end else if (w_accept) begin
            if (w_zero) begin
               r_quotient  <= '1;
               r_remainder <= bus.dividend[VW-1:0];
               r_dbz       <= 1'b1;
            end else begin
               r_dvd   <= bus.dividend;
               r_dvs   <= bus.divisor;
               r_prem  <= '0;
               r_quo_w <= '0;
               r_count <= CW'(DW - 1);
            end
         end
      end
   end

   assign bus.busy        = (r_state == S_CALC);
   assign bus.done        = (r_state == S_DONE);
   assign bus.quotient    = r_quotient;
   assign bus.remainder   = r_remainder;
   assign bus.div_by_zero = r_dbz;
endmodule
